exerion_rom_loader: RTL and testbench



---
 rtl/exerion_pkg.sv | 52 +++++
 rtl/exerion_rom_loader_if.sv | 25 ++
 rtl/exerion_rom_decode.sv | 33 +++
 rtl/exerion_rom_loader.sv | 145 ++++++++++++++
 tb/tb_exerion_rom_loader.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exerion_pkg.sv
// Shared constants for the Exerion ROM loader: region map, total ROM size and loader states.
package exerion_pkg;

    localparam int NUM_REGIONS = 6;

    localparam logic [24:0] ROM_TOTAL = 25'h10320;
    localparam logic [16:0] ROM_LAST  = 17'h1031F;

    localparam logic [24:0] R0_BASE = 25'h00000;
    localparam logic [24:0] R0_SIZE = 25'h06000;
    localparam logic [24:0] R1_BASE = 25'h06000;
    localparam logic [24:0] R1_SIZE = 25'h02000;
    localparam logic [24:0] R2_BASE = 25'h08000;
    localparam logic [24:0] R2_SIZE = 25'h02000;
    localparam logic [24:0] R3_BASE = 25'h0A000;
    localparam logic [24:0] R3_SIZE = 25'h04000;
    localparam logic [24:0] R4_BASE = 25'h0E000;
    localparam logic [24:0] R4_SIZE = 25'h02000;
    localparam logic [24:0] R5_BASE = 25'h10000;
    localparam logic [24:0] R5_SIZE = 25'h00320;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_HOLD,
        ST_READY
    } state_t;

    function automatic logic [24:0] region_base(input int idx);
        case (idx)
            0:       return R0_BASE;
            1:       return R1_BASE;
            2:       return R2_BASE;
            3:       return R3_BASE;
            4:       return R4_BASE;
            default: return R5_BASE;
        endcase
    endfunction

    function automatic logic [24:0] region_size(input int idx);
        case (idx)
            0:       return R0_SIZE;
            1:       return R1_SIZE;
            2:       return R2_SIZE;
            3:       return R3_SIZE;
            4:       return R4_SIZE;
            default: return R5_SIZE;
        endcase
    endfunction

endpackage

// File: rtl/exerion_rom_loader_if.sv
// HPS download port plus downstream ROM write port of the loader.
interface exerion_rom_loader_if;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic [5:0]  rom_we;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ready;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, rom_ready,
        input  ioctl_wait, rom_we, rom_addr, rom_data
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, rom_ready,
        output ioctl_wait, rom_we, rom_addr, rom_data
    );

endinterface

// File: rtl/exerion_rom_decode.sv
// Combinational map from a download byte address to a one-hot ROM region and region offset.
module exerion_rom_decode
    import exerion_pkg::*;
(
    input  logic [24:0]            addr_i,
    output logic [NUM_REGIONS-1:0] region_o,
    output logic [13:0]            offset_o,
    output logic                   out_of_range_o
);

    logic [13:0] offs [NUM_REGIONS];

    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
        localparam logic [24:0] BASE  = region_base(gi);
        localparam logic [24:0] LIMIT = region_base(gi) + region_size(gi);

        assign region_o[gi] = (addr_i >= BASE) && (addr_i < LIMIT);
        // Offset is deliberately truncated; the 24 KB main region wraps inside 14 bits.
        assign offs[gi]     = 14'(addr_i - BASE);
    end

    always_comb begin
        offset_o = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (region_o[i]) begin
                offset_o = offs[i];
            end
        end
    end

    assign out_of_range_o = (addr_i >= ROM_TOTAL);

endmodule

// File: rtl/exerion_rom_loader.sv
// Routes HPS ROM downloads into per-region ROM writes, captures DIP bytes and sequences core reset.
module exerion_rom_loader
    import exerion_pkg::*;
#(
    parameter logic [7:0] ROM_INDEX = 8'd0,
    parameter logic [7:0] DIP_INDEX = 8'd254,
    parameter int         POST_HOLD = 16
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    exerion_rom_loader_if.slave  bus,
    output logic [7:0]           dip1,
    output logic [7:0]           dip2,
    output logic                 core_reset_n,
    output logic                 rom_loaded,
    output logic                 rom_error,
    output logic [7:0]           checksum
);

    localparam int CW = (POST_HOLD > 1) ? $clog2(POST_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(POST_HOLD - 1);

    state_t                  state_q, state_d;
    logic                    dl_prev_q;
    logic [CW-1:0]           hold_cnt_q;
    logic                    hold_valid_q;
    logic [NUM_REGIONS-1:0]  rom_we_q;
    logic [13:0]             rom_addr_q;
    logic [7:0]              rom_data_q;
    logic [7:0]              dip1_q, dip2_q, checksum_q;
    logic                    loaded_q, error_q;
    logic [16:0]             max_addr_q;

    logic [NUM_REGIONS-1:0]  dec_region;
    logic [13:0]             dec_offset;
    logic                    dec_oor;
    logic                    wait_int, rom_strobe, accept, reject, dip_strobe;
    logic                    dl_rise, load_entry, ready_entry;

    exerion_rom_decode u_decode (
        .addr_i         (bus.ioctl_addr),
        .region_o       (dec_region),
        .offset_o       (dec_offset),
        .out_of_range_o (dec_oor)
    );

    assign wait_int   = hold_valid_q && !bus.rom_ready;
    assign rom_strobe = bus.ioctl_wr && (bus.ioctl_index == ROM_INDEX)
                        && (state_q == ST_LOAD) && !wait_int;
    assign accept     = rom_strobe && !dec_oor;
    assign reject     = rom_strobe && dec_oor;
    assign dip_strobe = bus.ioctl_wr && (bus.ioctl_index == DIP_INDEX)
                        && (bus.ioctl_addr[24:3] == 22'd0);
    assign dl_rise    = bus.ioctl_download && !dl_prev_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_READY: if (dl_rise && bus.ioctl_index == ROM_INDEX) state_d = ST_LOAD;
            ST_LOAD:           if (!bus.ioctl_download)                       state_d = ST_DRAIN;
            ST_DRAIN:          if (!hold_valid_q)                             state_d = ST_HOLD;
            ST_HOLD:           if (hold_cnt_q == HOLD_LAST)                   state_d = ST_READY;
            default:           state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        core_reset_n = (state_q == ST_READY);
        load_entry   = (state_d == ST_LOAD)  && (state_q != ST_LOAD);
        ready_entry  = (state_d == ST_READY) && (state_q != ST_READY);
    end

    // dl_prev_q resets high so a download already in progress at release is not taken as a new one.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_prev_q    <= 1'b1;
            hold_cnt_q   <= '0;
            hold_valid_q <= 1'b0;
            rom_we_q     <= '0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            dip1_q       <= 8'hFF;
            dip2_q       <= 8'hFF;
            checksum_q   <= '0;
            loaded_q     <= 1'b0;
            error_q      <= 1'b0;
            max_addr_q   <= '0;
        end else begin
            dl_prev_q  <= bus.ioctl_download;
            hold_cnt_q <= (state_q == ST_HOLD) ? hold_cnt_q + CW'(1) : '0;

            if (accept) begin
                hold_valid_q <= 1'b1;
                rom_we_q     <= dec_region;
                rom_addr_q   <= dec_offset;
                rom_data_q   <= bus.ioctl_dout;
            end else if (hold_valid_q && bus.rom_ready) begin
                hold_valid_q <= 1'b0;
                rom_we_q     <= '0;
            end

            if (load_entry) begin
                checksum_q <= '0;
                error_q    <= 1'b0;
                loaded_q   <= 1'b0;
                max_addr_q <= '0;
            end else begin
                if (accept) begin
                    checksum_q <= checksum_q + bus.ioctl_dout;
                    if (bus.ioctl_addr[16:0] > max_addr_q) begin
                        max_addr_q <= bus.ioctl_addr[16:0];
                    end
                end
                if (reject) begin
                    error_q <= 1'b1;
                end
                if (ready_entry) begin
                    loaded_q <= !error_q && (max_addr_q == ROM_LAST);
                end
            end

            if (dip_strobe && bus.ioctl_addr[2:0] == 3'd1) dip1_q <= bus.ioctl_dout;
            if (dip_strobe && bus.ioctl_addr[2:0] == 3'd2) dip2_q <= bus.ioctl_dout;
        end
    end

    assign bus.ioctl_wait = wait_int;
    assign bus.rom_we     = rom_we_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.rom_data   = rom_data_q;
    assign dip1           = dip1_q;
    assign dip2           = dip2_q;
    assign rom_loaded     = loaded_q;
    assign rom_error      = error_q;
    assign checksum       = checksum_q;

endmodule

// File: tb/tb_exerion_rom_loader.sv
// Directed bench for the Exerion ROM loader: downloads, back-pressure, DIP capture and reset.
module tb_exerion_rom_loader;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [7:0] dip1, dip2, checksum;
    logic       core_reset_n, rom_loaded, rom_error;

    int total = 0;
    int bad   = 0;
    int cyc;

    exerion_rom_loader_if bus_if ();

    exerion_rom_loader #(
        .ROM_INDEX (8'd0),
        .DIP_INDEX (8'd254),
        .POST_HOLD (16)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .bus          (bus_if),
        .dip1         (dip1),
        .dip2         (dip2),
        .core_reset_n (core_reset_n),
        .rom_loaded   (rom_loaded),
        .rom_error    (rom_error),
        .checksum     (checksum)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        bus_if.ioctl_addr = a;
        bus_if.ioctl_dout = d;
        bus_if.ioctl_wr   = 1'b1;
        step();
        bus_if.ioctl_wr   = 1'b0;
        $display("wr index=%0d addr=0x%05h data=0x%02h", bus_if.ioctl_index, a, d);
    endtask

    task automatic start_rom_download();
        bus_if.ioctl_index    = 8'd0;
        bus_if.ioctl_download = 1'b1;
        step();
        step();
    endtask

    task automatic finish_download(output int cycles);
        bus_if.ioctl_download = 1'b0;
        cycles = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            cycles++;
            if (core_reset_n === 1'b1) break;
        end
        check("ready_reached", core_reset_n, 1);
        $display("download ended, core_reset_n released after %0d cycles", cycles);
    endtask

    initial begin
        reset                 = 1'b1;
        bus_if.ioctl_download = 1'b0;
        bus_if.ioctl_wr       = 1'b0;
        bus_if.ioctl_addr     = '0;
        bus_if.ioctl_dout     = '0;
        bus_if.ioctl_index    = '0;
        bus_if.rom_ready      = 1'b1;
        step();
        step();

        // Reset state
        check("rst_rom_we",   bus_if.rom_we, 0);
        check("rst_rom_addr", bus_if.rom_addr, 0);
        check("rst_rom_data", bus_if.rom_data, 0);
        check("rst_wait",     bus_if.ioctl_wait, 0);
        check("rst_dip1",     dip1, 8'hFF);
        check("rst_dip2",     dip2, 8'hFF);
        check("rst_core_rn",  core_reset_n, 0);
        check("rst_loaded",   rom_loaded, 0);
        check("rst_error",    rom_error, 0);
        check("rst_checksum", checksum, 0);
        reset = 1'b0;
        step();

        // DIP transfer in IDLE
        bus_if.ioctl_index    = 8'd254;
        bus_if.ioctl_download = 1'b1;
        step();
        wr_byte(25'h0, 8'h00);
        wr_byte(25'h1, 8'h7F);
        wr_byte(25'h2, 8'h0A);
        wr_byte(25'h3, 8'h55);
        bus_if.ioctl_download = 1'b0;
        step();
        check("dip1_value",   dip1, 8'h7F);
        check("dip2_value",   dip2, 8'h0A);
        check("dip_core_rn",  core_reset_n, 0);
        check("dip_wait",     bus_if.ioctl_wait, 0);
        check("dip_no_we",    bus_if.rom_we, 0);

        // Full ROM download, data byte = low address byte
        start_rom_download();
        $display("full download of 0x10320 bytes");
        for (int a = 0; a < 32'h10320; a++) begin
            bus_if.ioctl_addr = 25'(a);
            bus_if.ioctl_dout = 8'(a);
            bus_if.ioctl_wr   = 1'b1;
            step();
            if (a == 32'h5FFF) begin
                check("full_5fff_we",   bus_if.rom_we, 6'b000001);
                check("full_5fff_addr", bus_if.rom_addr, 14'h1FFF);
                check("full_5fff_data", bus_if.rom_data, 8'hFF);
            end
            if (a == 32'h10000) begin
                check("full_10000_we",   bus_if.rom_we, 6'b100000);
                check("full_10000_addr", bus_if.rom_addr, 14'h0000);
                check("full_10000_data", bus_if.rom_data, 8'h00);
            end
        end
        bus_if.ioctl_wr = 1'b0;
        bus_if.ioctl_download = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("full_hold_core_rn", core_reset_n, 0);
        bus_if.ioctl_download = 1'b1;
        finish_download(cyc);
        check("full_hold_len", ((cyc + 10) >= 16 && (cyc + 10) <= 20) ? 1 : 0, 1);
        check("full_loaded",   rom_loaded, 1);
        check("full_error",    rom_error, 0);
        check("full_checksum", checksum, 8'h70);

        // Back-pressure: byte 0x12 at 0x8004 with rom_ready low for 5 cycles
        start_rom_download();
        check("load_core_rn", core_reset_n, 0);
        check("load_cleared", rom_loaded, 0);
        wr_byte(25'h8004, 8'h12);
        bus_if.rom_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_wait", bus_if.ioctl_wait, 1);
            check("bp_we",   bus_if.rom_we, 6'b000100);
            check("bp_addr", bus_if.rom_addr, 14'h0004);
            check("bp_data", bus_if.rom_data, 8'h12);
            if (i == 1) begin
                bus_if.ioctl_addr = 25'h8005;
                bus_if.ioctl_dout = 8'h34;
                bus_if.ioctl_wr   = 1'b1;
            end else begin
                bus_if.ioctl_wr   = 1'b0;
            end
            step();
        end
        bus_if.ioctl_wr  = 1'b0;
        bus_if.rom_ready = 1'b1;
        #1;
        check("bp_wait_end", bus_if.ioctl_wait, 0);
        check("bp_we_last",  bus_if.rom_we, 6'b000100);
        step();
        check("bp_we_clear", bus_if.rom_we, 0);
        check("bp_addr_hold", bus_if.rom_addr, 14'h0004);
        finish_download(cyc);
        check("bp_checksum", checksum, 8'h12);
        check("bp_loaded",   rom_loaded, 0);

        // Checksum wrap: 0x80 + 0x90
        start_rom_download();
        wr_byte(25'h0, 8'h80);
        wr_byte(25'h1, 8'h90);
        finish_download(cyc);
        check("sum_checksum", checksum, 8'h10);
        check("sum_error",    rom_error, 0);
        check("sum_loaded",   rom_loaded, 0);

        // Out-of-range byte at 0x10320
        start_rom_download();
        wr_byte(25'h0, 8'h01);
        wr_byte(25'h10320, 8'hAA);
        check("oor_no_we",  bus_if.rom_we, 0);
        check("oor_error",  rom_error, 1);
        finish_download(cyc);
        check("oor_loaded",   rom_loaded, 0);
        check("oor_error_rd", rom_error, 1);
        check("oor_checksum", checksum, 8'h01);

        // Reset in the middle of a download with a write pending
        start_rom_download();
        bus_if.rom_ready = 1'b0;
        wr_byte(25'h6001, 8'h33);
        check("mid_we",   bus_if.rom_we, 6'b000010);
        check("mid_wait", bus_if.ioctl_wait, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_we",       bus_if.rom_we, 0);
        check("mid_rst_addr",     bus_if.rom_addr, 0);
        check("mid_rst_data",     bus_if.rom_data, 0);
        check("mid_rst_wait",     bus_if.ioctl_wait, 0);
        check("mid_rst_dip1",     dip1, 8'hFF);
        check("mid_rst_checksum", checksum, 0);
        check("mid_rst_error",    rom_error, 0);
        check("mid_rst_core_rn",  core_reset_n, 0);
        step();
        reset = 1'b0;
        bus_if.rom_ready = 1'b1;
        step();
        wr_byte(25'h0, 8'h44);
        check("post_rst_ignored_we",  bus_if.rom_we, 0);
        check("post_rst_ignored_sum", checksum, 0);
        bus_if.ioctl_download = 1'b0;
        step();
        step();
        check("post_rst_idle", core_reset_n, 0);

        start_rom_download();
        wr_byte(25'h0, 8'h05);
        wr_byte(25'h1031F, 8'h06);
        check("again_we",   bus_if.rom_we, 6'b100000);
        check("again_addr", bus_if.rom_addr, 14'h031F);
        check("again_data", bus_if.rom_data, 8'h06);
        finish_download(cyc);
        check("again_checksum", checksum, 8'h0B);
        check("again_loaded",   rom_loaded, 1);
        check("again_error",    rom_error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
